// File: rtl/tdm_demux8.sv
// Receive side of the 8:1 TDM link: rebuilds d[7:0] from the slot stream with hunt/sync framing.
// Define TDM_PARITY_EN to add a trailing even-parity slot per frame that gates delivery of the word.
module tdm_demux8 #(
  parameter int N_CH        = 8,
  parameter int LOSS_FRAMES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            din_en,
  input  logic            frame_sync,
  output logic [N_CH-1:0] d_out,
  output logic            valid,
  output logic            locked,
  output logic [2:0]      slot,
  output logic            sync_err,
  output logic            par_err
);

  typedef enum logic {HUNT, SYNC} state_t;

  localparam logic [3:0] LAST_DATA = 4'(N_CH - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_FRAMES - 1);
`ifdef TDM_PARITY_EN
  localparam logic [3:0] PAR_SLOT  = 4'(N_CH);
`endif

  state_t          state_q, state_d;
  logic [3:0]      slot_q, slot_d;
  logic [N_CH-1:0] stage_q, stage_d;
  logic [3:0]      miss_q, miss_d;
  logic [N_CH-1:0] d_out_q, d_out_d;
  logic            valid_q, valid_d;
  logic            locked_q, locked_d;
  logic            sync_err_q, sync_err_d;
  logic            par_err_q, par_err_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    stage_d    = stage_q;
    miss_d     = miss_q;
    d_out_d    = d_out_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    par_err_d  = 1'b0;

    if (din_en) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            stage_d[0] = din;
            slot_d     = 4'd1;
            miss_d     = 4'd0;
            state_d    = SYNC;
          end
        end

        SYNC: begin
          if (frame_sync && slot_q != 4'd0) begin
            // Misplaced marker: drop the partial frame and realign on this strobe.
            sync_err_d = 1'b1;
            stage_d[0] = din;
            slot_d     = 4'd1;
            miss_d     = 4'd0;
          end else if (slot_q == 4'd0) begin
            if (frame_sync) begin
              miss_d     = 4'd0;
              stage_d[0] = din;
              slot_d     = 4'd1;
            end else if (miss_q == LOSS_LAST) begin
              state_d = HUNT;
              miss_d  = 4'd0;
              slot_d  = 4'd0;
            end else begin
              miss_d     = miss_q + 4'd1;
              stage_d[0] = din;
              slot_d     = 4'd1;
            end
`ifdef TDM_PARITY_EN
          end else if (slot_q == PAR_SLOT) begin
            if (din == ^stage_q) begin
              d_out_d = stage_q;
              valid_d = 1'b1;
            end else begin
              par_err_d = 1'b1;
            end
            slot_d = 4'd0;
          end else begin
            stage_d[slot_q[2:0]] = din;
            slot_d               = slot_q + 4'd1;
          end
`else
          end else if (slot_q == LAST_DATA) begin
            stage_d[N_CH-1] = din;
            d_out_d         = {din, stage_q[N_CH-2:0]};
            valid_d         = 1'b1;
            slot_d          = 4'd0;
          end else begin
            stage_d[slot_q[2:0]] = din;
            slot_d               = slot_q + 4'd1;
          end
`endif
        end

        default: begin
          state_d = HUNT;
          slot_d  = 4'd0;
          miss_d  = 4'd0;
        end
      endcase
    end

    locked_d = (state_d == SYNC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= 4'd0;
      stage_q    <= '0;
      miss_q     <= 4'd0;
      d_out_q    <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      stage_q    <= stage_d;
      miss_q     <= miss_d;
      d_out_q    <= d_out_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
      par_err_q  <= par_err_d;
    end
  end

  assign d_out    = d_out_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  // During the parity slot the counter reads 8, which shows as 0 on the 3-bit port.
  assign slot     = slot_q[2:0];
  assign sync_err = sync_err_q;
  assign par_err  = par_err_q;

endmodule
